// File: rtl/wolf_irq_pkg.sv
// Shared constants for the interrupt controller:
// register word offsets and the default source count.
package wolf_irq_pkg;

   localparam int N_SRC_DEFAULT = 32;

   localparam logic [31:0] OFF_PEND  = 32'd0;
   localparam logic [31:0] OFF_MASK  = 32'd1;
   localparam logic [31:0] OFF_EDGE  = 32'd2;
   localparam logic [31:0] OFF_RAW   = 32'd3;
   localparam logic [31:0] OFF_FORCE = 32'd4;

   function automatic logic [31:0] srcMask(input int n);
      logic [31:0] m;
      if (n >= 32) m = '1;
      else m = (32'd1 << n) - 32'd1;
      return m;
   endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU register bus and interrupt lines of the controller.
// master drives sources and bus; slave is the controller.
interface irq_controller_if;
   logic [31:0] irqSrc;
   logic [31:0] inputAddr;
   logic [31:0] inputData;
   logic        wrEn;
   logic [31:0] outputAddr;
   logic [31:0] outputData;
   logic [31:0] irqOut;
   logic        irqAny;

   modport master (
      output irqSrc, inputAddr, inputData,
      output wrEn, outputAddr,
      input  outputData, irqOut, irqAny
   );

   modport slave (
      input  irqSrc, inputAddr, inputData,
      input  wrEn, outputAddr,
      output outputData, irqOut, irqAny
   );
endinterface

// File: rtl/irq_sync.sv
// Two-flop synchroniser plus a previous-value flop,
// giving a clean level and a one-cycle rising-edge strobe.
module irq_sync #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] rawIn,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] syncQ;
   logic [WIDTH-1:0] prevQ;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta  <= '0;
         syncQ <= '0;
         prevQ <= '0;
      end else begin
         meta  <= rawIn;
         syncQ <= meta;
         prevQ <= syncQ;
      end
   end

   assign level = syncQ;
   assign rise  = syncQ & ~prevQ;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: pending/mask/edge
// registers, W1C clear, force-set and a registered irqOut.
module irq_controller
   import wolf_irq_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
   parameter int          N_SRC     = N_SRC_DEFAULT
) (
   input logic             clk,
   input logic             rst,
   irq_controller_if.slave bus
);

   localparam logic [31:0] VALID = srcMask(N_SRC);

   logic [N_SRC-1:0] syncLevel;
   logic [N_SRC-1:0] syncRise;
   logic [31:0]      level;
   logic [31:0]      rise;

   logic [31:0] pend;
   logic [31:0] mask;
   logic [31:0] edgeMode;
   logic [31:0] irqOutQ;

   logic [31:0] wrOff;
   logic [31:0] rdOff;
   logic [31:0] wrData;
   logic        wrPend;
   logic        wrMask;
   logic        wrEdge;
   logic        wrForce;
   logic [31:0] clr;
   logic [31:0] frc;
   logic [31:0] setV;

   irq_sync #(
      .WIDTH(N_SRC)
   ) uSync (
      .clk  (clk),
      .rst  (rst),
      .rawIn(bus.irqSrc[N_SRC-1:0]),
      .level(syncLevel),
      .rise (syncRise)
   );

   assign level = 32'(syncLevel);
   assign rise  = 32'(syncRise);

   assign wrOff   = bus.inputAddr - BASE_ADDR;
   assign rdOff   = bus.outputAddr - BASE_ADDR;
   assign wrData  = bus.inputData & VALID;
   assign wrPend  = bus.wrEn && (wrOff == OFF_PEND);
   assign wrMask  = bus.wrEn && (wrOff == OFF_MASK);
   assign wrEdge  = bus.wrEn && (wrOff == OFF_EDGE);
   assign wrForce = bus.wrEn && (wrOff == OFF_FORCE);

   assign clr = wrPend ? wrData : '0;
   assign frc = wrForce ? wrData : '0;

   // set/force are OR-ed after the clear so they win
   assign setV = ((edgeMode & rise) | (~edgeMode & level))
               & VALID;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend     <= '0;
         mask     <= '0;
         edgeMode <= '0;
         irqOutQ  <= '0;
      end else begin
         pend    <= (pend & ~clr) | setV | frc;
         irqOutQ <= pend & mask;
         if (wrMask) mask <= wrData;
         if (wrEdge) edgeMode <= wrData;
      end
   end

   assign bus.irqOut = irqOutQ;
   assign bus.irqAny = |irqOutQ;

   always_comb begin
      bus.outputData = '0;
      case (rdOff)
         OFF_PEND: bus.outputData = pend;
         OFF_MASK: bus.outputData = mask;
         OFF_EDGE: bus.outputData = edgeMode;
         OFF_RAW:  bus.outputData = level;
         default:  bus.outputData = '0;
      endcase
   end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL take parameter BASE_ADDR, default 32'h0000_F000, word address of register PEND; the other registers follow at consecutive word addresses.
REQ-002 SHALL take parameter N_SRC, default 32, number of interrupt sources (1..32); bits at or above N_SRC read 0 and ignore writes.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port irqSrc  input  32  raw peripheral interrupt lines, asynchronous to clk.
REQ-006 SHALL have port inputAddr  input  32  CPU write address (CPU dataOutAddr).
REQ-007 SHALL have port inputData  input  32  CPU write data.
REQ-008 SHALL have port wrEn  input  1  CPU write strobe, one write per high cycle.
REQ-009 SHALL have port outputAddr  input  32  CPU read address (CPU dataInAddr).
REQ-010 SHALL have port outputData  output  32  register read data, to the data-read mux.
REQ-011 SHALL have port irqOut  output  32  masked pending vector, to the flow controller IRQ input.
REQ-012 SHALL have port irqAny  output  1  OR-reduction of irqOut.

Function
REQ-013 Register map (offset from BASE_ADDR): +0 PEND (read; write-1-to-clear), +1 MASK (read/write, 1 = enabled), +2 EDGE (read/write, 1 = rising-edge, 0 = level), +3 RAW (read-only, synchronised sources), +4 FORCE (write-only, write-1-to-set PEND; reads 0).
REQ-014 Each irqSrc bit SHALL pass through a 2-flop synchroniser; a third flop holds the previous synchronised value for edge detection.
REQ-015 Edge mode: PEND bit set when synchronised value is 1 and previous value is 0.
REQ-016 Level mode: PEND bit set on every cycle the synchronised value is 1.
REQ-017 PEND next value = (PEND & ~clear) | set | force; set and force win over a same-cycle W1C clear.
REQ-018 A W1C clear of a level-mode bit whose source is still high SHALL leave PEND at 1.
REQ-019 irqOut SHALL be registered: irqOut <= PEND & MASK, one cycle after PEND changes.
REQ-020 Latency: irqSrc bit high before rising edge k (first sampled at k) yields PEND at edge k+2 and irqOut at edge k+3.
REQ-021 A source pulse shorter than one clk period is not guaranteed to be captured.
REQ-022 Clearing a MASK bit SHALL not alter PEND; re-enabling it re-asserts irqOut on the next edge if PEND is still set.
REQ-023 Changing EDGE SHALL not alter PEND.
REQ-024 Writes with wrEn high to addresses outside BASE_ADDR..BASE_ADDR+4, or to RAW, SHALL have no effect.
REQ-025 outputData SHALL be combinational from outputAddr and current register state, same cycle, 0 for unmapped addresses.
REQ-026 A read of PEND in the cycle of a same-address W1C write SHALL return the pre-write value.

Reset
REQ-027 While rst is high: PEND, MASK, EDGE, synchroniser flops, previous-value flops and irqOut all 0; irqAny 0; outputData reflects the zeroed registers.
REQ-028 A source that is already high at reset release SHALL register as a rising edge in edge mode (previous value resets to 0).
REQ-029 Reset asserted mid-operation SHALL discard all pending interrupts immediately, without waiting for a clock edge.

Structure
REQ-030 Register offsets (PEND..FORCE) and the default source count SHALL live in the shared package wolf_irq_pkg.
REQ-031 The synchroniser and edge detector SHALL be one sub-module, irq_sync, parameterised by width, with outputs for level and rising edge.
REQ-032 Address decode, register file and irqOut register SHALL stay in irq_controller.

Verification
REQ-033 Reset, MASK = 0x1, EDGE = 0x1, irqSrc[0] 0->1 before edge k: PEND = 0x1 at k+2, irqOut = 0x1 and irqAny = 1 at k+3.
REQ-034 Edge-mode bit 0 pending; write 0x1 to PEND: irqOut[0] = 0 one edge later; no re-set while irqSrc[0] stays high.
REQ-035 Level mode, irqSrc[3] held high, MASK = 0x8; write 0x8 to PEND: PEND stays 0x8 and irqOut stays 0x8; drop irqSrc[3] then clear: PEND = 0.
REQ-036 MASK = 0, FORCE write 0x80000000: PEND = 0x80000000, irqOut = 0; then MASK = 0x80000000: irqOut = 0x80000000 one edge later.
REQ-037 Same-cycle rising edge on bit 5 and W1C of bit 5: PEND[5] = 1 afterwards; read of BASE_ADDR+7 returns 0; write to BASE_ADDR+3 changes nothing.
REQ-038 PEND = 0xFF with MASK = 0xFF, assert rst between clock edges: irqOut = 0 and PEND reads 0 before the next rising edge.
